// File: rtl/pi_digit_stream.sv
// pi_digit_stream: snapshots the base-1000 limb bus of the pi engine and
// streams it as BCD digits, integer digit first, over a valid/ready handshake.
module pi_digit_stream #(
  parameter int L      = 47,
  parameter int N      = 10,
  parameter int DIGITS = 100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [L*N-1:0] sum,
  output logic           busy,
  output logic           dig_valid,
  input  logic           dig_ready,
  output logic [3:0]     dig_data,
  output logic           dig_int,
  output logic           dig_last,
  output logic           done,
  output logic           err
);

  localparam int KW = $clog2(L);
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [KW-1:0] KTOP  = KW'(L - 1);
  localparam logic [CW-1:0] CLAST = CW'(DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, CONV, EMIT, DONE
  } state_t;

  state_t         state;
  logic [L*N-1:0] snap;
  logic [KW-1:0]  k;
  logic [CW-1:0]  cnt;
  logic [9:0]     r;
  logic [3:0]     h;
  logic [3:0]     t;
  logic [3:0]     u;
  logic [1:0]     pos;
  logic [N-1:0]   limb;
  logic           xfer;

  assign limb = snap[N*k +: N];
  assign xfer = dig_valid && dig_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      dig_valid <= 1'b0;
      dig_data  <= 4'd0;
      dig_int   <= 1'b0;
      dig_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      k         <= '0;
      cnt       <= '0;
      r         <= '0;
      h         <= '0;
      t         <= '0;
      u         <= '0;
      pos       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            snap  <= sum;
            k     <= KTOP;
            cnt   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          h     <= '0;
          t     <= '0;
          state <= CONV;
          // out-of-range limbs saturate so the stream stays BCD
          if (int'(limb) > 999) begin
            err <= 1'b1;
            r   <= 10'd999;
          end else begin
            r <= 10'(limb);
          end
        end
        CONV: begin
          unique case (1'b1)
            (r >= 10'd100): begin
              r <= r - 10'd100;
              h <= h + 4'd1;
            end
            (r < 10'd100 && r >= 10'd10): begin
              r <= r - 10'd10;
              t <= t + 4'd1;
            end
            default: begin
              u         <= r[3:0];
              pos       <= '0;
              dig_valid <= 1'b1;
              state     <= EMIT;
              if (k == KTOP) begin
                dig_data <= r[3:0];
                dig_int  <= 1'b1;
              end else begin
                dig_data <= h;
                dig_last <= (cnt == CLAST);
              end
            end
          endcase
        end
        EMIT: begin
          if (xfer) begin
            if (dig_int) begin
              dig_valid <= 1'b0;
              dig_int   <= 1'b0;
              k         <= k - KW'(1);
              state     <= LOAD;
            end else begin
              cnt <= cnt + CW'(1);
              if (dig_last) begin
                dig_valid <= 1'b0;
                dig_last  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
              end else if (pos == 2'd2) begin
                dig_valid <= 1'b0;
                k         <= k - KW'(1);
                state     <= LOAD;
              end else begin
                pos      <= pos + 2'd1;
                dig_data <= (pos == 2'd0) ? t : u;
                dig_last <= (cnt + CW'(1) == CLAST);
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_digit_stream.sv
// tb_pi_digit_stream: digit-stream bench with a reference built from
// plain limb arithmetic, random ready patterns and a DIGITS=4 vector table.
module tb_pi_digit_stream;

  localparam int L  = 47;
  localparam int N  = 10;
  localparam int D  = 100;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           start_a = 1'b0;
  logic           ready_a = 1'b0;
  logic [L*N-1:0] sum_a   = '0;
  logic           busy_a, valid_a, int_a, last_a, done_a, err_a;
  logic [3:0]     data_a;

  logic           start_b = 1'b0;
  logic           ready_b = 1'b0;
  logic [L*N-1:0] sum_b   = '0;
  logic           busy_b, valid_b, int_b, last_b, done_b, err_b;
  logic [3:0]     data_b;

  pi_digit_stream #(.L(L), .N(N), .DIGITS(D)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .sum(sum_a),
    .busy(busy_a), .dig_valid(valid_a), .dig_ready(ready_a),
    .dig_data(data_a), .dig_int(int_a), .dig_last(last_a),
    .done(done_a), .err(err_a)
  );

  pi_digit_stream #(.L(L), .N(N), .DIGITS(DB)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .sum(sum_b),
    .busy(busy_b), .dig_valid(valid_b), .dig_ready(ready_b),
    .dig_data(data_b), .dig_int(int_b), .dig_last(last_b),
    .done(done_b), .err(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int limbs [L];
  int exp_q [$];
  int gap_q [$];
  bit exp_err;

  int pi_frac [34] = '{141, 592, 653, 589, 793, 238, 462, 643, 383, 279,
                       502, 884, 197, 169, 399, 375, 105, 820, 974, 944,
                       592, 307, 816, 406, 286, 208, 998, 628, 34,  825,
                       342, 117, 67,  982};

  typedef struct {
    int          li;
    int          f0;
    int          f1;
    int          f2;
    logic [19:0] d;
    bit          e;
  } vec_t;

  vec_t tab [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [L*N-1:0] packv(input int a [L]);
    logic [L*N-1:0] p;
    p = '0;
    for (int i = 0; i < L; i++) p[N*i +: N] = N'(a[i]);
    return p;
  endfunction

  // Expected digits straight from base-1000 arithmetic.
  function automatic void model(input int digits);
    int v;
    int nf;
    exp_q.delete();
    gap_q.delete();
    exp_err = 1'b0;
    v = limbs[L-1];
    if (v > 999) begin v = 999; exp_err = 1'b1; end
    exp_q.push_back(v % 10);
    gap_q.push_back(-1);
    nf = (digits + 2) / 3;
    for (int j = 0; j < nf; j++) begin
      v = limbs[L-2-j];
      if (v > 999) begin v = 999; exp_err = 1'b1; end
      for (int d = 0; d < 3; d++) begin
        if (exp_q.size() < digits + 1) begin
          exp_q.push_back(d == 0 ? v / 100 : (d == 1 ? (v / 10) % 10 : v % 10));
          gap_q.push_back(d == 0 ? (v / 100) + ((v / 10) % 10) + 2 : -1);
        end
      end
    end
  endfunction

  task automatic rand_limbs();
    for (int i = 0; i < L; i++) limbs[i] = $urandom_range(0, 999);
  endtask

  task automatic set_pi();
    rand_limbs();
    limbs[L-1] = 3;
    for (int j = 0; j < 34; j++) limbs[L-2-j] = pi_frac[j];
  endtask

  task automatic start_a_run();
    @(negedge clk);
    sum_a   = packv(limbs);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("busy_after_start", busy_a, 1);
    check("err_clear_on_start", err_a, 0);
  endtask

  // mode 0: ready=1, 1: random, 2: 5-cycle stall mid-limb then random,
  // 3: ready=1 with a start pulse and sum change while busy
  task automatic run_a(input int mode, input int stop_after);
    int   nb = 0;
    int   cyc = 0;
    int   gap = 0;
    int   stall = 0;
    bit   pulsed = 1'b0;
    bit   fin = 1'b0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [6:0] pout = '0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0;
      if (mode == 0 || mode == 3) begin
        ready_a = 1'b1;
      end else if (mode == 2 && stall < 5) begin
        if (nb == 5 && valid_a) begin
          ready_a = 1'b0;
          stall++;
        end else begin
          ready_a = 1'b1;
        end
      end else begin
        ready_a = 1'($urandom_range(0, 1));
      end
      if (mode == 3 && nb == 10 && !pulsed) begin
        start_a = 1'b1;
        sum_a   = ~sum_a;
        pulsed  = 1'b1;
      end
      if (pv && !pr)
        check("hold_stable", {valid_a, data_a, int_a, last_a}, pout);
      check("busy_high", busy_a, 1);
      check("no_early_done", done_a, 0);
      if (!valid_a) begin
        gap++;
      end else begin
        if (!pv && mode == 0 && nb < gap_q.size() && gap_q[nb] >= 0)
          check($sformatf("conv_gap_beat%0d", nb), gap, gap_q[nb]);
        gap = 0;
      end
      if (valid_a && ready_a) begin
        if (nb >= exp_q.size()) begin
          check("extra_beat", nb, exp_q.size());
          fin = 1'b1;
        end else begin
          check($sformatf("beat%0d", nb), {data_a, int_a, last_a},
                {4'(exp_q[nb]), nb == 0, nb == exp_q.size() - 1});
        end
        nb++;
        if (stop_after > 0 && nb == stop_after) return;
        if (nb == exp_q.size()) fin = 1'b1;
      end
      pv   = valid_a;
      pr   = ready_a;
      pout = {valid_a, data_a, int_a, last_a};
      if (cyc > 5000) begin
        check("stream_timeout", nb, exp_q.size());
        fin = 1'b1;
      end
    end
    @(negedge clk);
    start_a = 1'b0;
    check("done_after_last", {done_a, busy_a, valid_a}, 3'b100);
    @(negedge clk);
    check("done_one_cycle", done_a, 0);
    check("err_final", err_a, exp_err);
  endtask

  initial begin
    tab[0] = '{3,    141, 592,  653,  20'h31415, 1'b0};
    tab[1] = '{12,   7,   0,    1,    20'h20070, 1'b0};
    tab[2] = '{1023, 1000, 5,   0,    20'h99990, 1'b1};
    tab[3] = '{0,    999, 999,  0,    20'h09999, 1'b0};
    tab[4] = '{5,    50,  1023, 0,    20'h50509, 1'b1};
    tab[5] = '{4,    0,   0,    1023, 20'h40000, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a", {busy_a, valid_a, data_a, int_a, last_a, done_a, err_a}, 0);
    check("rst_b", {busy_b, valid_b, data_b, int_b, last_b, done_b, err_b}, 0);
    rst = 1'b0;

    set_pi();
    model(D);
    check("model_len", exp_q.size(), D + 1);
    start_a_run();
    run_a(0, 0);
    start_a_run();
    run_a(2, 0);
    start_a_run();
    run_a(3, 0);

    start_a_run();
    run_a(1, 20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst", {busy_a, valid_a, data_a, int_a, last_a, done_a, err_a}, 0);
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_rst", {done_a, valid_a, busy_a}, 0);
    end
    start_a_run();
    run_a(0, 0);

    rand_limbs();
    limbs[L-2] = 7;
    limbs[L-3] = 0;
    limbs[L-4] = 999;
    limbs[L-5] = 1023;
    model(D);
    start_a_run();
    run_a(0, 0);
    check("err_sticky", err_a, 1);

    repeat (4) begin
      rand_limbs();
      model(D);
      start_a_run();
      run_a(1, 0);
    end

    foreach (tab[r]) begin
      int lb [L];
      int nb;
      int cyc;
      bit p;
      for (int i = 0; i < L; i++) lb[i] = $urandom_range(0, 999);
      lb[L-1] = tab[r].li;
      lb[L-2] = tab[r].f0;
      lb[L-3] = tab[r].f1;
      lb[L-4] = tab[r].f2;
      @(negedge clk);
      sum_b   = packv(lb);
      start_b = 1'b1;
      ready_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      nb  = 0;
      cyc = 0;
      p   = 1'b0;
      while (nb < 5 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        start_b = (nb == 2 && !p);
        if (start_b) begin
          sum_b = ~sum_b;
          p     = 1'b1;
        end
        if (valid_b) begin
          check($sformatf("tab%0d_beat%0d", r, nb), {data_b, int_b, last_b},
                {tab[r].d[4*(4-nb) +: 4], nb == 0, nb == 4});
          nb++;
        end
      end
      start_b = 1'b0;
      if (nb < 5) check($sformatf("tab%0d_timeout", r), nb, 5);
      @(negedge clk);
      check($sformatf("tab%0d_done", r), {done_b, busy_b, valid_b}, 3'b100);
      check($sformatf("tab%0d_err", r), err_b, tab[r].e);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
